// File: rtl/calc_pkg.sv
// ============================================================================
// calc_pkg : shared types and constants for the calculator sequencer slice
// Revision : 1.0
// ============================================================================
`default_nettype none

package calc_pkg;

    localparam int OPND_W = 4;
    localparam int RES_W  = 8;
    localparam logic [RES_W-1:0] DIV_ERR_VALUE = 8'hFF;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        EXEC   = 2'b10,
        HOLD   = 2'b11
    } state_t;

    // Enable vector order: [0] add, [1] sub, [2] mul, [3] div
    function automatic logic [3:0] op_onehot(input opcode_t op);
        return 4'b0001 << op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/calc_edge_detect.sv
// ============================================================================
// calc_edge_detect : registered rising-edge detector for a synchronous button
// Revision : 1.0
// ============================================================================
`default_nettype none

module calc_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic btn_q;
    logic btn_d;

    always_comb begin
        btn_d = btn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign rise = btn & ~btn_q;

endmodule

`default_nettype wire

// File: rtl/calc_op_sequencer.sv
// ============================================================================
// calc_op_sequencer : captures operands/opcode, enables one arithmetic unit
//                     for a settle window, then registers the shared result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPND_W-1:0] sw_data,
    input  logic              load_btn,
    input  logic [1:0]        op_sel,
    input  logic              clr,
    input  logic [RES_W-1:0]  result_bus,
    output logic [OPND_W-1:0] op_a,
    output logic [OPND_W-1:0] op_b,
    output logic              en_add,
    output logic              en_sub,
    output logic              en_mul,
    output logic              en_div,
    output logic [RES_W-1:0]  result,
    output logic              result_valid,
    output logic              neg,
    output logic              div_err,
    output logic              busy
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic load_edge;

    calc_edge_detect u_load_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (load_btn),
        .rise  (load_edge)
    );

    state_t              state_q,  state_d;
    opcode_t             opcode_q, opcode_d;
    logic [OPND_W-1:0]   op_a_q,   op_a_d;
    logic [OPND_W-1:0]   op_b_q,   op_b_d;
    logic [3:0]          cnt_q,    cnt_d;
    logic [3:0]          en_q,     en_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                valid_q,  valid_d;
    logic                neg_q,    neg_d;
    logic                derr_q,   derr_d;
    logic                div_zero;

    assign div_zero = (opcode_q == OP_DIV) && (op_b_q == '0);

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        cnt_d    = cnt_q;
        en_d     = 4'b0000;
        result_d = result_q;
        valid_d  = valid_q;
        neg_d    = neg_q;
        derr_d   = derr_q;
        if (clr) begin
            state_d  = LOAD_A;
            opcode_d = OP_ADD;
            op_a_d   = '0;
            op_b_d   = '0;
            cnt_d    = '0;
            result_d = '0;
            valid_d  = 1'b0;
            neg_d    = 1'b0;
            derr_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (load_edge) begin
                        op_a_d  = sw_data;
                        state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (load_edge) begin
                        op_b_d   = sw_data;
                        opcode_d = opcode_t'(op_sel);
                        cnt_d    = '0;
                        state_d  = EXEC;
                        // A divide by zero never wakes the divider
                        if (!((opcode_t'(op_sel) == OP_DIV) && (sw_data == '0))) begin
                            en_d = op_onehot(opcode_t'(op_sel));
                        end
                    end
                end
                EXEC: begin
                    cnt_d = 4'(cnt_q + 4'd1);
                    en_d  = en_q;
                    if (cnt_q == SETTLE_LAST) begin
                        en_d     = 4'b0000;
                        result_d = div_zero ? DIV_ERR_VALUE : result_bus;
                        valid_d  = 1'b1;
                        neg_d    = (opcode_q == OP_SUB) && (op_a_q < op_b_q);
                        derr_d   = div_zero;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (load_edge) begin
                        op_a_d  = sw_data;
                        valid_d = 1'b0;
                        neg_d   = 1'b0;
                        derr_d  = 1'b0;
                        state_d = LOAD_B;
                    end
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD_A;
            opcode_q <= OP_ADD;
            op_a_q   <= '0;
            op_b_q   <= '0;
            cnt_q    <= '0;
            en_q     <= 4'b0000;
            result_q <= '0;
            valid_q  <= 1'b0;
            neg_q    <= 1'b0;
            derr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            neg_q    <= neg_d;
            derr_q   <= derr_d;
        end
    end

    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign en_add       = en_q[0];
    assign en_sub       = en_q[1];
    assign en_mul       = en_q[2];
    assign en_div       = en_q[3];
    assign result       = result_q;
    assign result_valid = valid_q;
    assign neg          = neg_q;
    assign div_err      = derr_q;
    assign busy         = (state_q == EXEC);

endmodule

`default_nettype wire

// File: tb/tb_calc_op_sequencer.sv
// ============================================================================
// tb_calc_op_sequencer : directed bench with a result scoreboard
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_calc_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw_data = 4'd0;
    logic       load_btn = 1'b0;
    logic [1:0] op_sel = 2'b00;
    logic       clr = 1'b0;

    logic [7:0] result_bus,  result_bus_1;
    logic [3:0] op_a, op_b, op_a_1, op_b_1;
    logic       en_add, en_sub, en_mul, en_div;
    logic       en_add_1, en_sub_1, en_mul_1, en_div_1;
    logic [7:0] result, result_1;
    logic       result_valid, neg, div_err, busy;
    logic       result_valid_1, neg_1, div_err_1, busy_1;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    // Behavioural arithmetic units sharing an OR'ed result bus
    function automatic logic [7:0] unit_bus(input logic [3:0] en, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] r;
        r = 8'h00;
        if (en[0]) r = r | ({4'd0, a} + {4'd0, b});
        if (en[1]) r = r | {4'd0, 4'(a - b)};
        if (en[2]) r = r | ({4'd0, a} * {4'd0, b});
        if (en[3] && b != 4'd0) r = r | {4'd0, a / b};
        return r;
    endfunction

    assign result_bus   = unit_bus({en_div, en_mul, en_sub, en_add}, op_a, op_b);
    assign result_bus_1 = unit_bus({en_div_1, en_mul_1, en_sub_1, en_add_1}, op_a_1, op_b_1);

    calc_op_sequencer #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sw_data(sw_data), .load_btn(load_btn),
        .op_sel(op_sel), .clr(clr), .result_bus(result_bus),
        .op_a(op_a), .op_b(op_b), .en_add(en_add), .en_sub(en_sub),
        .en_mul(en_mul), .en_div(en_div), .result(result),
        .result_valid(result_valid), .neg(neg), .div_err(div_err), .busy(busy)
    );

    calc_op_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sw_data(sw_data), .load_btn(load_btn),
        .op_sel(op_sel), .clr(clr), .result_bus(result_bus_1),
        .op_a(op_a_1), .op_b(op_b_1), .en_add(en_add_1), .en_sub(en_sub_1),
        .en_mul(en_mul_1), .en_div(en_div_1), .result(result_1),
        .result_valid(result_valid_1), .neg(neg_1), .div_err(div_err_1), .busy(busy_1)
    );

    // Expected {result, neg, div_err}
    function automatic logic [9:0] model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        logic [7:0] r;
        logic       n;
        logic       d;
        n = 1'b0;
        d = 1'b0;
        case (op)
            2'b00: r = {4'd0, a} + {4'd0, b};
            2'b01: begin r = {4'd0, 4'(a - b)}; n = (a < b); end
            2'b10: r = {4'd0, a} * {4'd0, b};
            default: begin
                if (b == 4'd0) begin r = 8'hFF; d = 1'b1; end
                else r = {4'd0, a / b};
            end
        endcase
        return {r, n, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] v);
        sw_data  = v;
        load_btn = 1'b1;
        step();
        load_btn = 1'b0;
        step();
    endtask

    task automatic finish_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        logic [3:0] exp_en;
        logic [9:0] exp;
        int k;
        int en_cycles;
        exp_en = (op == 2'b11 && b == 4'd0) ? 4'b0000 : (4'b0001 << op);
        sb.push_back(model(a, b, op));
        op_sel   = op;
        sw_data  = b;
        load_btn = 1'b1;
        step();
        load_btn = 1'b0;
        op_sel   = ~op;
        chk("busy_exec", busy, 1'b1);
        k = 1;
        en_cycles = 0;
        while (k <= 20) begin
            if (result_valid) break;
            if ({en_div, en_mul, en_sub, en_add} != 4'b0000) begin
                en_cycles++;
                chk("enable_sel", {en_div, en_mul, en_sub, en_add}, exp_en);
            end
            step();
            k++;
        end
        chk("latency", k, 3);
        chk("enable_cycles", en_cycles, (exp_en == 4'b0000) ? 0 : 2);
        chk("enables_off_hold", {en_div, en_mul, en_sub, en_add}, 4'b0000);
        chk("busy_hold", busy, 1'b0);
        exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
        chk("result", result, exp[9:2]);
        chk("neg", neg, exp[1]);
        chk("div_err", div_err, exp[0]);
        chk("op_a_kept", op_a, a);
        chk("op_b_kept", op_b, b);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        press(a);
        chk("op_a_load", op_a, a);
        chk("valid_cleared", result_valid, 1'b0);
        chk("neg_cleared", neg, 1'b0);
        chk("div_err_cleared", div_err, 1'b0);
        chk("busy_load_b", busy, 1'b0);
        finish_op(a, b, op);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        step();
        step();
        chk("rst_op_a", op_a, 4'd0);
        chk("rst_result", result, 8'd0);
        chk("rst_flags", {result_valid, neg, div_err, busy}, 4'b0000);
        chk("rst_enables", {en_div, en_mul, en_sub, en_add}, 4'b0000);
        rst_n = 1'b1;
        step();

        // Asynchronous reset while the multiplier is enabled
        press(4'd3);
        op_sel   = 2'b10;
        sw_data  = 4'd4;
        load_btn = 1'b1;
        step();
        load_btn = 1'b0;
        chk("mul_enabled", en_mul, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_enables", {en_div, en_mul, en_sub, en_add}, 4'b0000);
        chk("async_rst_regs", {op_a, op_b, result}, 16'h0000);
        chk("async_rst_flags", {result_valid, neg, div_err, busy}, 4'b0000);
        step();
        rst_n = 1'b1;
        step();

        run_op(4'd9, 4'd3, 2'b01);
        run_op(4'd3, 4'd9, 2'b01);
        run_op(4'd5, 4'd0, 2'b11);
        run_op(4'd7, 4'd8, 2'b00);

        step();
        step();
        chk("hold_result", result, 8'h0F);
        chk("hold_valid", result_valid, 1'b1);

        // Held button: one capture only
        sw_data  = 4'd2;
        load_btn = 1'b1;
        repeat (10) step();
        chk("held_valid", result_valid, 1'b0);
        chk("held_op_a", op_a, 4'd2);
        chk("held_op_b", op_b, 4'd8);
        chk("held_busy", busy, 1'b0);
        load_btn = 1'b0;
        step();
        finish_op(4'd2, 4'd3, 2'b10);

        // clr wins over a simultaneous load edge in LOAD_B
        press(4'd6);
        chk("load_b_op_a", op_a, 4'd6);
        sw_data  = 4'd11;
        load_btn = 1'b1;
        clr      = 1'b1;
        step();
        clr      = 1'b0;
        load_btn = 1'b0;
        step();
        chk("clr_regs", {op_a, op_b, result}, 16'h0000);
        chk("clr_flags", {result_valid, neg, div_err, busy}, 4'b0000);
        press(4'd1);
        chk("after_clr_op_a", op_a, 4'd1);
        chk("after_clr_load_b", busy, 1'b0);
        finish_op(4'd1, 4'd2, 2'b00);

        // Single-cycle settle window
        press(4'd4);
        op_sel   = 2'b00;
        sw_data  = 4'd5;
        load_btn = 1'b1;
        step();
        load_btn = 1'b0;
        chk("s1_enable", en_add_1, 1'b1);
        chk("s1_not_valid", result_valid_1, 1'b0);
        step();
        chk("s1_enable_off", {en_div_1, en_mul_1, en_sub_1, en_add_1}, 4'b0000);
        chk("s1_valid", result_valid_1, 1'b1);
        chk("s1_result", result_1, model(4'd4, 4'd5, 2'b00) >> 2);
        chk("s2_still_enabled", en_add, 1'b1);
        step();
        chk("s2_valid", result_valid, 1'b1);
        chk("s2_result", result, model(4'd4, 4'd5, 2'b00) >> 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Upstream control stage for the 4-bit arithmetic units (add/sub/mul/div); sub unit is one of its consumers.
- Captures operands A and B from switches on button presses and latches the opcode.
- Drives each unit's one-hot enable for a fixed settle window, then registers the shared 8-bit result bus.
- Presents the registered result with a valid flag to the display stage.

Parameters:
- SETTLE_CYCLES, 2, cycles the selected enable is held before the result bus is sampled; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sw_data  in  4  operand switches.
- load_btn  in  1  operand-load button; already debounced and synchronous to clk.
- op_sel  in  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- clr  in  1  synchronous clear, level-sensitive.
- result_bus  in  8  OR of all unit outputs; a disabled unit drives 0.
- op_a  out  4  registered operand A, fans out to all units.
- op_b  out  4  registered operand B, fans out to all units.
- en_add, en_sub, en_mul, en_div  out  1 each  unit enables, one-hot or all zero.
- result  out  8  registered result.
- result_valid  out  1  result holds a completed operation.
- neg  out  1  SUB only: set when A < B (result is two's-complement).
- div_err  out  1  DIV only: set when B == 0.
- busy  out  1  high while in EXEC.

Behaviour:
- Reset (async, rst_n low):
  - state = LOAD_A; op_a, op_b, result, settle counter, latched opcode = 0.
  - All enables, result_valid, neg, div_err, busy = 0; edge-detect register = 0.
- Load edge: load_edge = load_btn & ~load_btn_q, with load_btn_q registered. A held button counts once.
- LOAD_A: on load_edge, op_a <= sw_data and go to LOAD_B.
- LOAD_B: on load_edge:
  - op_b <= sw_data; opcode latched from op_sel; counter <= 0; go to EXEC.
  - op_sel changes after this point are ignored until the next operation.
- EXEC:
  - busy = 1; exactly one enable is high, selected by the latched opcode; the enable is registered.
  - Counter increments each cycle. On the cycle the counter equals SETTLE_CYCLES-1, sample result_bus into result.
  - On that same cycle, set result_valid, neg = (opcode==SUB && op_a<op_b), div_err = (opcode==DIV && op_b==0); go to HOLD.
  - The enable is high for exactly SETTLE_CYCLES cycles. Latency from the LOAD_B edge to result_valid is SETTLE_CYCLES+1 cycles.
- DIV with B==0: do not enable the divider. Result is forced to 8'hFF, div_err = 1, same latency.
- HOLD: enables 0; result, result_valid, neg, div_err held. On load_edge:
  - op_a <= sw_data; result_valid, neg, div_err cleared; go to LOAD_B.
  - This chains a new operation without a clear.
- clr (any state, including mid-EXEC): next cycle returns to LOAD_A with the same values as reset. clr has priority over load_edge.
- load_edge during EXEC is ignored. The edge register still updates, so no stale edge fires later.
- Widths:
  - result_bus is taken as-is.
  - ADD/MUL zero-extend into 8 bits.
  - SUB wraps 4-bit two's-complement; sign is carried by neg only.
- Enables are never high outside EXEC, and never more than one at a time.

Decomposition:
- Shared package calc_pkg:
  - opcode enum (ADD/SUB/MUL/DIV = 2'b00..2'b11).
  - state enum (LOAD_A, LOAD_B, EXEC, HOLD).
  - DIV_ERR_VALUE = 8'hFF.
  - Operand width 4 and result width 8 as constants.
- One natural sub-module: calc_edge_detect, the registered rising-edge detector for load_btn; reusable for other buttons.

Test Plan:
- Reset mid-EXEC with en_mul high: drop rst_n -> all enables and outputs 0 immediately, state LOAD_A.
- sw=4'd9, load; sw=4'd3, op_sel=01, load; model drives result_bus=8'h06 while en_sub -> en_sub high for 2 cycles, result=8'h06, result_valid after 3 cycles, neg=0.
- A=3, B=9, SUB, model bus=8'h0A -> result=8'h0A, neg=1.
- A=5, B=0, DIV -> en_div never asserted, result=8'hFF, div_err=1.
- HOLD after ADD 7+8 (result 8'h0F), then sw=2 load -> result_valid=0, op_a=2, state LOAD_B. Button held high for 10 cycles -> exactly one capture.
- clr asserted during LOAD_B, together with a load_edge -> state LOAD_A, op_a=0, no capture. SETTLE_CYCLES=1 run -> enable one cycle, latency 2.
